// File: rtl/stream_arbiter.sv
// stream_arbiter: N-channel round-robin merger of FWFT source FIFOs into one
// word stream. Grants are bounded by MAX_BURST unless the owner holds the lock.
// It has a channel enable mask, a source-channel tag on every output word and
// saturating per-channel word counters.
module stream_arbiter #(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 16,
    parameter int CH_BITS   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      CLK,
    input  logic                      RST_B,
    input  logic [CHANNELS-1:0]       WRITE_REQ,
    input  logic [CHANNELS-1:0]       HOLD_REQ,
    input  logic [CHANNELS*WIDTH-1:0] DATA_IN,
    input  logic [CHANNELS-1:0]       CH_ENABLE,
    output logic [CHANNELS-1:0]       READ_GRANT,
    input  logic                      READY_OUT,
    output logic                      WRITE_OUT,
    output logic [WIDTH-1:0]          DATA_OUT,
    output logic [CH_BITS-1:0]        CHANNEL_OUT,
    input  logic                      CNT_CLEAR,
    output logic [CHANNELS*16-1:0]    WORD_CNT
);

    typedef enum logic {S_IDLE, S_OWN} state_t;

    state_t             r_state;
    logic [CH_BITS-1:0] r_ptr;
    logic [CH_BITS-1:0] r_owner;
    logic [7:0]         r_burst_cnt;
    logic               r_write_out;
    logic [WIDTH-1:0]   r_data_out;
    logic [CH_BITS-1:0] r_channel_out;
    logic [15:0]        r_word_cnt [CHANNELS];

    logic [CHANNELS-1:0] w_eligible;
    logic                w_found;
    logic [CH_BITS-1:0]  w_winner;
    int                  w_best;
    logic                w_owner_req;
    logic                w_owner_hold;
    logic [WIDTH-1:0]    w_owner_data;
    logic                w_load_en;
    logic                w_release;
    logic                w_pop;

    assign w_eligible = WRITE_REQ & CH_ENABLE;
    assign w_load_en  = !r_write_out || READY_OUT;

    // Round-robin pick: the eligible channel nearest after r_ptr (wrapping) wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_best   = CHANNELS;
        for (int j = 0; j < CHANNELS; j++) begin
            if (w_eligible[j] &&
                (((j + CHANNELS - 1 - int'(r_ptr)) % CHANNELS) < w_best)) begin
                w_found  = 1'b1;
                w_winner = CH_BITS'(j);
                w_best   = (j + CHANNELS - 1 - int'(r_ptr)) % CHANNELS;
            end
        end
    end

    // Select the current owner's request, hold and head-of-FIFO word.
    always_comb begin
        w_owner_req  = 1'b0;
        w_owner_hold = 1'b0;
        w_owner_data = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            if (r_owner == CH_BITS'(j)) begin
                w_owner_req  = WRITE_REQ[j];
                w_owner_hold = HOLD_REQ[j];
                w_owner_data = DATA_IN[j*WIDTH +: WIDTH];
            end
        end
    end

    // A held owner never releases; otherwise it lets go when dry or out of burst.
    assign w_release = !w_owner_hold &&
                       (!w_owner_req || (r_burst_cnt == 8'(MAX_BURST)));
    assign w_pop     = RST_B && (r_state == S_OWN) && !w_release &&
                       w_owner_req && w_load_en;

    // One-hot pop strobe back to the owner's FIFO.
    always_comb begin
        READ_GRANT = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            READ_GRANT[j] = w_pop && (r_owner == CH_BITS'(j));
        end
    end

    // Arbitration FSM: IDLE picks an owner, OWN streams until release.
    always_ff @(posedge CLK) begin
        if (!RST_B) begin
            r_state     <= S_IDLE;
            r_ptr       <= CH_BITS'(CHANNELS - 1);
            r_owner     <= '0;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner     <= w_winner;
                        r_burst_cnt <= '0;
                        r_state     <= S_OWN;
                    end
                end
                S_OWN: begin
                    if (w_release) begin
                        r_ptr   <= r_owner;
                        r_state <= S_IDLE;
                    end else if (w_pop && (r_burst_cnt != 8'(MAX_BURST))) begin
                        r_burst_cnt <= r_burst_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output register: load on pop, drop valid once the word has been taken.
    always_ff @(posedge CLK) begin
        if (!RST_B) begin
            r_write_out   <= 1'b0;
            r_data_out    <= '0;
            r_channel_out <= '0;
        end else if (w_pop) begin
            r_write_out   <= 1'b1;
            r_data_out    <= w_owner_data;
            r_channel_out <= r_owner;
        end else if (r_write_out && READY_OUT) begin
            r_write_out   <= 1'b0;
        end
    end

    // Saturating per-channel pop counters; clear beats a same-cycle increment.
    always_ff @(posedge CLK) begin
        for (int j = 0; j < CHANNELS; j++) begin
            if (!RST_B || CNT_CLEAR) begin
                r_word_cnt[j] <= '0;
            end else if (READ_GRANT[j] && (r_word_cnt[j] != 16'hFFFF)) begin
                r_word_cnt[j] <= r_word_cnt[j] + 16'd1;
            end
        end
    end

    assign WRITE_OUT   = r_write_out;
    assign DATA_OUT    = r_data_out;
    assign CHANNEL_OUT = r_channel_out;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_cnt
        assign WORD_CNT[g*16 +: 16] = r_word_cnt[g];
    end

endmodule
